// File: rtl/ika2151_timer_bank.sv
// rtl/ika2151_timer_bank.sv - bank of independent prescaled up-counters with overflow flags
//
// Purpose: NCH independent timer channels. Each channel divides the qualified
// timebase tick by (P+1) in its prescaler, then counts up from LOAD. When it
// advances at all-ones it overflows: it reloads LOAD, pulses o_OVFL for one
// enabled-edge interval and, when enabled, sets a sticky flag. One-shot
// channels halt after the overflow until RUN is cycled low and high again.
//
// Ports:
//   i_EMUCLK    master clock, all state on the rising edge
//   i_MRST_n    asynchronous active-low reset
//   i_CEN_n     active-low clock enable; state only moves on enabled edges
//   i_TICK      timebase tick, qualified by i_CEN_n
//   i_LOAD      per-channel reload value, channel k at [k*CNTW +: CNTW]
//   i_PRESC     per-channel prescale terminal P, channel k at [k*PREW +: PREW]
//   i_RUN       per-channel run; low holds the channel in load state
//   i_ONESHOT   per-channel mode: 1 one-shot, 0 auto-reload
//   i_IRQ_EN    per-channel flag-set enable
//   i_FLAG_CLR  per-channel flag clear request
//   o_CNT       counter readback, straight from the count registers
//   o_FLAG      sticky overflow flags
//   o_OVFL      one-interval overflow strobes
//   o_IRQ_n     active-low interrupt, NOR of all flags

module ika2151_timer_bank #(
  parameter int NCH  = 2,
  parameter int CNTW = 10,
  parameter int PREW = 4
) (
  input  logic                i_EMUCLK,
  input  logic                i_MRST_n,
  input  logic                i_CEN_n,
  input  logic                i_TICK,
  input  logic [NCH*CNTW-1:0] i_LOAD,
  input  logic [NCH*PREW-1:0] i_PRESC,
  input  logic [NCH-1:0]      i_RUN,
  input  logic [NCH-1:0]      i_ONESHOT,
  input  logic [NCH-1:0]      i_IRQ_EN,
  input  logic [NCH-1:0]      i_FLAG_CLR,
  output logic [NCH*CNTW-1:0] o_CNT,
  output logic [NCH-1:0]      o_FLAG,
  output logic [NCH-1:0]      o_OVFL,
  output logic                o_IRQ_n
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNTW-1:0] cnt;
    logic [PREW-1:0] ps;
    logic            done;
    logic            flag;
    logic            ovfl;

    logic [CNTW-1:0] load_k;
    logic [PREW-1:0] presc_k;
    logic            tick_ok;
    logic            advance;
    logic            wrap;

    assign load_k  = i_LOAD[k*CNTW +: CNTW];
    assign presc_k = i_PRESC[k*PREW +: PREW];
    assign tick_ok = i_RUN[k] & ~done & i_TICK;
    // Equality compare only: if P drops below PS mid-count, PS runs on
    // through all-ones and wraps to 0 before matching again.
    assign advance = tick_ok & (ps == presc_k);
    assign wrap    = advance & (&cnt);

    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
      if (!i_MRST_n) begin
        cnt  <= '0;
        ps   <= '0;
        done <= 1'b0;
        flag <= 1'b0;
        ovfl <= 1'b0;
      end else if (!i_CEN_n) begin
        ovfl <= wrap;

        if (!i_RUN[k]) begin
          cnt  <= load_k;
          ps   <= '0;
          done <= 1'b0;
        end else if (tick_ok) begin
          if (!advance) begin
            ps <= ps + 1'b1;
          end else begin
            ps <= '0;
            if (wrap) begin
              // LOAD is sampled here, so a change while running only
              // shows up at the next reload.
              cnt <= load_k;
              if (i_ONESHOT[k]) begin
                done <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        // A setting overflow beats a simultaneous clear request.
        if (wrap && i_IRQ_EN[k]) begin
          flag <= 1'b1;
        end else if (i_FLAG_CLR[k]) begin
          flag <= 1'b0;
        end
      end
    end

    assign o_CNT[k*CNTW +: CNTW] = cnt;
    assign o_FLAG[k]             = flag;
    assign o_OVFL[k]             = ovfl;
  end

  assign o_IRQ_n = ~|o_FLAG;

endmodule

// File: doc/ika2151_timer_bank.md
IKA2151_TIMER_BANK -- requirements
Module: IKA2151_timer_bank

Interface
REQ-001 SHALL have parameters: NCH, default 2, channel count; CNTW, default 10, counter width; PREW, default 4, prescaler width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_EMUCLK  in  1  emulator master clock, all state on rising edge.
- i_MRST_n  in  1  reset, asynchronous, active-low.
- i_CEN_n  in  1  clock enable, active-low; state advances only on edges where i_CEN_n=0 ("enabled edge").
- i_TICK  in  1  timebase tick, qualified by i_CEN_n.
- i_LOAD  in  NCH*CNTW  per-channel reload value, channel k at [k*CNTW +: CNTW].
- i_PRESC  in  NCH*PREW  per-channel prescale terminal P; advance every P+1 ticks.
- i_RUN  in  NCH  per-channel run.
- i_ONESHOT  in  NCH  1 = one-shot mode, 0 = auto-reload mode.
- i_IRQ_EN  in  NCH  flag-set enable.
- i_FLAG_CLR  in  NCH  flag clear request, level-sampled on enabled edges.
- o_CNT  out  NCH*CNTW  counter readback.
- o_FLAG  out  NCH  sticky overflow flags.
- o_OVFL  out  NCH  overflow strobe.
- o_IRQ_n  out  1  active-low interrupt.

Function
REQ-003 SHALL keep each channel independent; the per-channel state is counter CNT[CNTW], prescaler PS[PREW], DONE bit, FLAG, and OVFL.
REQ-004 SHALL, on an enabled edge with RUN=0, set CNT:=LOAD, PS:=0 and DONE:=0.
REQ-005 SHALL, on an enabled edge with RUN=1, DONE=0 and i_TICK=1, do one of two things:
- if PS≠P: PS:=PS+1.
- else: PS:=0 and the counter advances.
REQ-006 SHALL hold CNT and PS on an enabled edge with RUN=1 and i_TICK=0, and also on any edge with DONE=1.
REQ-007 SHALL, on an advance, set CNT:=CNT+1 unless CNT is all-ones; an advance at all-ones is an overflow.
REQ-008 SHALL, on overflow, set CNT:=LOAD, sampled at that edge, so a LOAD change while running takes effect only at the next reload.
REQ-009 SHALL, on overflow with ONESHOT=1, also set DONE:=1; the channel stays halted until RUN is deasserted on an enabled edge and reasserted.
REQ-010 SHALL register o_OVFL[k]=1 on the overflow edge and clear it on the next enabled edge; it is asserted for exactly one enabled-edge interval and does not depend on i_IRQ_EN.
REQ-011 SHALL set FLAG[k] on an overflow edge when i_IRQ_EN[k]=1; if i_FLAG_CLR[k]=1 on the same edge, set wins.
REQ-012 SHALL clear FLAG[k] on an enabled edge with i_FLAG_CLR[k]=1 and no setting overflow; deasserting i_IRQ_EN SHALL NOT clear an existing flag.
REQ-013 SHALL drive o_IRQ_n as the combinational NOR of all FLAG bits.
REQ-014 SHALL drive o_CNT directly from the CNT registers, with zero latency.
REQ-015 SHALL leave all state unchanged on edges with i_CEN_n=1, including an overflow pending on PS/CNT.
REQ-016 SHALL, with P=0, advance on every qualified tick; with P=2^PREW-1, advance every 2^PREW ticks.
REQ-017 SHALL treat a change of i_PRESC mid-count as follows: the comparison uses the current P; if PS>P, PS keeps counting and wraps naturally through all-ones to 0, with no special case.

Reset
REQ-018 SHALL, on i_MRST_n=0 and asynchronously, clear CNT, PS, DONE, FLAG and OVFL for all channels: o_CNT=0, o_FLAG=0, o_OVFL=0, o_IRQ_n=1.
REQ-019 SHALL resume the REQ-004 behaviour on the first enabled edge after reset release; reset asserted mid-count discards the count and any pending strobe.

Verification
REQ-020 SHALL cover auto-reload:
- stimulus: NCH=2, CNTW=10, ch0 LOAD=1020, P=0, IRQ_EN=1, RUN=1, TICK=1, CEN_n=0.
- response: o_CNT0 reads 1021, 1022, 1023, then 1020 on the 4th edge, with o_OVFL0=1 for one edge, o_FLAG0=1 and o_IRQ_n=0.
- repeats every 4 edges after that.
REQ-021 SHALL cover the prescaler:
- stimulus: ch1 LOAD=1022, P=3.
- response: CNT advances every 4th tick; overflow on tick 8; ch0 unaffected.
REQ-022 SHALL cover one-shot:
- stimulus: ch0 ONESHOT=1, LOAD=1022, P=0.
- response: overflow on edge 2; CNT holds at 1022 with no further o_OVFL0.
- stimulus: RUN 1→0→1.
- response: overflow again 2 edges later.
REQ-023 SHALL cover flag priority:
- stimulus: i_FLAG_CLR0=1 held across an overflow edge with IRQ_EN=1.
- response: FLAG0=1 after that edge, then 0 on the next enabled edge.
- stimulus: IRQ_EN=0.
- response: o_OVFL pulses, FLAG stays 0.
REQ-024 SHALL cover clock-enable gating: CEN_n toggling 0/1 each clock shall give an identical o_CNT sequence per enabled edge, with CNT frozen on disabled edges.
REQ-025 SHALL cover reset mid-count: i_MRST_n=0 asynchronously between edges with CNT=1023 and FLAG=1 gives o_CNT=0, o_FLAG=0, o_IRQ_n=1 immediately, with no o_OVFL after release.
